// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared stall/flush FSM state encoding
package pipeline_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MD_WAIT  = 2'd2,
    FLUSH    = 2'd3
  } stall_state_e;
endpackage

// File: rtl/stall_stats_counter.sv
// stall_stats_counter: saturating counters of stall cycles and front-end flushes
module stall_stats_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  // count each stalled cycle and each flush pulse, holding at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
  end
endmodule

// File: rtl/stall_flush_controller.sv
// stall_flush_controller: pipeline stall/flush FSM; STALL_STATS_EN adds stall/flush counters
module stall_flush_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lu_hazard,
  input  logic               branch_taken_ex,
  input  logic               muldiv_start_ex,
  input  logic               muldiv_done,
  output logic               pc_write_en,
  output logic               if_id_write_en,
  output logic               id_ex_write_en,
  output logic               if_id_flush,
  output logic               id_ex_bubble,
  output logic               ex_mem_bubble,
  output logic [STATE_W-1:0] stall_state,
`ifdef STALL_STATS_EN
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]   flush_count,
`endif
  output logic               md_timeout_err
);
  localparam int WAIT_W = $clog2(MD_TIMEOUT + 1);
  stall_state_e state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic md_err, md_err_nx;
  logic pc_en, if_id_en, id_ex_en, flush, id_bub, ex_bub;
  // state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      md_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      md_err   <= md_err_nx;
    end
  end
  // next state and Mealy control outputs; LU_STALL and FLUSH use the defaults and return to RUN
  always_comb begin
    state_nx    = RUN;
    wait_cnt_nx = '0;
    md_err_nx   = md_err;
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    flush       = 1'b0;
    id_bub      = 1'b0;
    ex_bub      = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken_ex) begin
          flush    = 1'b1;
          id_bub   = 1'b1;
          state_nx = FLUSH;
        end else if (muldiv_start_ex && !muldiv_done) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_ex_en = 1'b0;
          ex_bub   = 1'b1;
          state_nx = MD_WAIT;
        end else if (!muldiv_start_ex && lu_hazard) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          id_bub   = 1'b1;
          state_nx = LU_STALL;
        end
      end
      MD_WAIT: begin
        if (!muldiv_done && wait_cnt == WAIT_W'(MD_TIMEOUT)) begin
          md_err_nx = 1'b1;
        end else if (!muldiv_done) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_en    = 1'b0;
          ex_bub      = 1'b1;
          wait_cnt_nx = wait_cnt + 1'b1;
          state_nx    = MD_WAIT;
        end
      end
      default: ;
    endcase
  end
  assign pc_write_en    = rst_n & pc_en;
  assign if_id_write_en = rst_n & if_id_en;
  assign id_ex_write_en = rst_n & id_ex_en;
  assign if_id_flush    = rst_n & flush;
  assign id_ex_bubble   = rst_n & id_bub;
  assign ex_mem_bubble  = rst_n & ex_bub;
  assign stall_state    = state;
  assign md_timeout_err = md_err;
`ifdef STALL_STATS_EN
  stall_stats_counter #(.CNT_W(CNT_W)) u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (rst_n & !pc_en),
    .flush        (if_id_flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif
endmodule

// File: tb/tb_stall_flush_controller.sv
// tb_stall_flush_controller: directed scoreboard bench for stall_flush_controller
module tb_stall_flush_controller;
  logic clk = 0, rst_n = 1, lu = 0, br = 0, ms = 0, md = 0;
  logic pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [1:0] stall_state;
  logic md_timeout_err;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [8:0] obs;
  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  stall_flush_controller #(.MD_TIMEOUT(4), .CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .lu_hazard       (lu),
    .branch_taken_ex (br),
    .muldiv_start_ex (ms),
    .muldiv_done     (md),
    .pc_write_en     (pc_write_en),
    .if_id_write_en  (if_id_write_en),
    .id_ex_write_en  (id_ex_write_en),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .ex_mem_bubble   (ex_mem_bubble),
    .stall_state     (stall_state),
`ifdef STALL_STATS_EN
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
`endif
    .md_timeout_err  (md_timeout_err)
  );

  always #5 clk = ~clk;
  assign obs = {pc_write_en, if_id_write_en, id_ex_write_en, if_id_flush, id_ex_bubble,
                ex_mem_bubble, stall_state, md_timeout_err};

  task automatic compare_next();
    exp_t x;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %b expected an entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.v) else begin
        n_bad++;
        $error("FAIL %s: observed %b expected %b", x.tag, obs, x.v);
      end
    end
  endtask

  // expected layout: {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_bubble, ex_mem_bubble, state[1:0], err}
  task automatic step(input logic r, input logic l, input logic b, input logic m, input logic d,
                      input logic [8:0] e, input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; lu = l; br = b; ms = m; md = d;
    x.tag = tag;
    x.v   = e;
    sb.push_back(x);
    @(negedge clk);
    compare_next();
  endtask

  initial begin
    #2 rst_n = 0;
    step(0, 1, 0, 1, 0, 9'b000_000_00_0, "reset_state");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "idle_run");
    step(1, 1, 0, 0, 0, 9'b001_010_00_0, "lu_stall_issue");
    step(1, 1, 0, 0, 0, 9'b111_000_01_0, "lu_stall_hold_ignores_lu");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "lu_back_to_run");
    step(1, 1, 1, 0, 0, 9'b111_110_00_0, "branch_beats_lu");
    step(1, 1, 0, 1, 0, 9'b111_000_11_0, "flush_ignores_lu_md");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "flush_back_to_run");
    step(1, 1, 0, 1, 1, 9'b111_000_00_0, "md_start_done_same_cycle");
    step(1, 0, 0, 1, 0, 9'b000_001_00_0, "md_start");
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 0, 9'b000_001_10_0, "md_wait");
    step(1, 0, 0, 1, 1, 9'b111_000_10_0, "md_done_release");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "md_after_done");
    step(1, 1, 0, 0, 0, 9'b001_010_00_0, "lu_stall_issue2");
    step(1, 0, 1, 0, 0, 9'b111_000_01_0, "lu_stall_ignores_branch");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "lu_stall_no_flush");
    step(1, 0, 0, 1, 0, 9'b000_001_00_0, "to_start");
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 0, 9'b000_001_10_0, "to_wait");
    step(1, 0, 0, 1, 0, 9'b111_000_10_0, "to_release");
    step(1, 0, 0, 0, 0, 9'b111_000_00_1, "to_err_set");
    step(1, 1, 0, 0, 0, 9'b001_010_00_1, "to_err_sticky_lu");
    step(1, 0, 0, 0, 0, 9'b111_000_01_1, "to_err_sticky_stall");
    step(1, 0, 0, 1, 0, 9'b000_001_00_1, "rst_md_start");
    step(1, 0, 0, 1, 0, 9'b000_001_10_1, "rst_md_wait");
    step(0, 1, 1, 1, 0, 9'b000_000_00_0, "rst_mid_wait");
    step(1, 0, 0, 0, 0, 9'b111_000_00_0, "rst_release");
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0, 0, 9'b001_010_00_0, "stats_lu");
      step(1, 0, 0, 0, 0, 9'b111_000_01_0, "stats_lu_hold");
      if (k < 2) begin
        step(1, 0, 1, 0, 0, 9'b111_110_00_0, "stats_branch");
        step(1, 0, 0, 0, 0, 9'b111_000_11_0, "stats_flush");
      end
    end
`ifdef STALL_STATS_EN
    n_cmp++;
    assert (stall_cycles === 32'd3) else begin
      n_bad++;
      $error("FAIL stall_cycles: observed %0d expected 3", stall_cycles);
    end
    n_cmp++;
    assert (flush_count === 32'd2) else begin
      n_bad++;
      $error("FAIL flush_count: observed %0d expected 2", flush_count);
    end
`endif
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stall_flush_controller.md
STALL_FLUSH_CONTROLLER -- requirements
Module: stall_flush_controller

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 40, max cycles waited in MD_WAIT before abort.
REQ-002 SHALL have parameter CNT_W, default 32, width of stall statistics counters.
REQ-003 SHALL have CLK  in  1  single clock; all state on rising edge.
REQ-004 SHALL have RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have LU_HAZARD  in  1  load-use hazard from hazard detection for the instruction in ID.
REQ-006 SHALL have BRANCH_TAKEN_EX  in  1  branch/jump resolved taken in EX.
REQ-007 SHALL have MULDIV_START_EX  in  1  M-extension instruction present in EX.
REQ-008 SHALL have MULDIV_DONE  in  1  mul/div result valid.
REQ-009 SHALL have PC_WRITE_EN, IF_ID_WRITE_EN, ID_EX_WRITE_EN  out  1 each  pipeline register enables.
REQ-010 SHALL have IF_ID_FLUSH, ID_EX_BUBBLE, EX_MEM_BUBBLE  out  1 each  insert NOP into the named register.
REQ-011 SHALL have STALL_STATE  out  2  current FSM state encoding.
REQ-012 SHALL have MD_TIMEOUT_ERR  out  1  sticky mul/div timeout flag.

Function
REQ-013 SHALL implement FSM states RUN=0, LU_STALL=1, MD_WAIT=2, FLUSH=3; outputs Mealy (same-cycle response to inputs).
REQ-014 SHALL, in any state not listed below, drive all WRITE_EN=1 and all FLUSH/BUBBLE=0.
REQ-015 SHALL prioritise in RUN: BRANCH_TAKEN_EX > MULDIV_START_EX > LU_HAZARD.
REQ-016 SHALL, in RUN with BRANCH_TAKEN_EX=1: PC_WRITE_EN=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1; next state FLUSH.
REQ-017 SHALL, in RUN with MULDIV_START_EX=1, MULDIV_DONE=0: PC/IF_ID/ID_EX_WRITE_EN=0, EX_MEM_BUBBLE=1; next MD_WAIT.
REQ-018 SHALL, in RUN with MULDIV_START_EX=1 and MULDIV_DONE=1 same cycle: no stall, remain RUN.
REQ-019 SHALL, in RUN with LU_HAZARD=1 only: PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1; next LU_STALL.
REQ-020 SHALL hold LU_STALL exactly one cycle, ignore LU_HAZARD there (no double bubble), then RUN; BRANCH_TAKEN_EX there is ignored (EX holds bubble).
REQ-021 SHALL hold FLUSH exactly one cycle, ignoring LU_HAZARD and MULDIV_START_EX, then RUN.
REQ-022 SHALL, in MD_WAIT with MULDIV_DONE=0, keep REQ-017 outputs and increment wait counter.
REQ-023 SHALL, in MD_WAIT with MULDIV_DONE=1, release all enables same cycle and go RUN; counter cleared.
REQ-024 SHALL, when wait counter reaches MD_TIMEOUT, set MD_TIMEOUT_ERR, release enables that cycle, go RUN.
REQ-025 SHALL size the wait counter to clog2(MD_TIMEOUT+1) bits; no wrap possible.

Reset
REQ-026 SHALL, while RESET=0 (any state, mid-stall included), force STALL_STATE=RUN, counters=0, MD_TIMEOUT_ERR=0, all WRITE_EN=0, all FLUSH/BUBBLE=0, independent of inputs.
REQ-027 SHALL clear MD_TIMEOUT_ERR only by reset.

Configuration
REQ-028 SHALL compile stall statistics when STALL_STATS_EN is defined: outputs STALL_CYCLES (CNT_W, +1 each cycle PC_WRITE_EN=0) and FLUSH_COUNT (CNT_W, +1 per IF_ID_FLUSH pulse), saturating at all-ones.
REQ-029 SHALL, without STALL_STATS_EN, omit those ports and registers entirely; control behaviour identical.

Structure
REQ-030 SHALL place state encoding constants and their 2-bit width in shared package pipeline_ctrl_pkg.
REQ-031 SHALL implement REQ-028 counters as sub-module stall_stats_counter, instantiated only under STALL_STATS_EN.

Verification
REQ-032 SHALL cover: LU_HAZARD=1 one cycle in RUN -> PC/IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1 that cycle, STALL_STATE=1 next, RUN after.
REQ-033 SHALL cover: BRANCH_TAKEN_EX=1 and LU_HAZARD=1 together -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1, PC_WRITE_EN=1, STATE=3 next cycle.
REQ-034 SHALL cover: MULDIV_START_EX=1, MULDIV_DONE after 5 cycles -> enables low 5 cycles, EX_MEM_BUBBLE=1, released on DONE cycle.
REQ-035 SHALL cover: MD_TIMEOUT=4, DONE never -> MD_TIMEOUT_ERR=1 after 4 MD_WAIT cycles, STATE=0, flag persists.
REQ-036 SHALL cover: RESET low during MD_WAIT -> immediate STATE=0, all outputs 0; after release, enables=1.
REQ-037 SHALL cover (STALL_STATS_EN): 3 LU stalls + 2 branches -> STALL_CYCLES=3, FLUSH_COUNT=2.
